fetch_cycle: RTL

//  IF stage of the 5-stage RISC-V pipeline. Owns the PC register, PC+4 adder and next-PC mux,

---
 rtl/riscv_pkg.sv | 6 +
 rtl/program_counter.sv | 25 ++
 rtl/fetch_cycle.sv | 91 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V pipeline stages.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/program_counter.sv
// PC register: async active-low reset to RESET_PC, loads pc_next when en is high.
module program_counter
  import riscv_pkg::*;
#(
  parameter int               W     = XLEN,
  parameter logic [W-1:0]     RST_PC = RESET_PC[W-1:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] pc_next,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_reg;

  // Hold the fetch address unless enabled to take the next value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    pc_reg <= RST_PC;
    else if (en) pc_reg <= pc_next;
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_cycle.sv
// IF stage: PC, PC+4, next-PC select, IF/ID register and accepted-instruction counter.
module fetch_cycle
  import riscv_pkg::*;
#(
  parameter int                XLEN_P     = XLEN,
  parameter logic [XLEN_P-1:0] RESET_PC_P = RESET_PC[XLEN_P-1:0],
  parameter logic [31:0]       NOP_P      = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              pc_src_e,
  input  logic [XLEN_P-1:0] pc_target_e,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  output logic [XLEN_P-1:0] pc_f,
  output logic [31:0]       instr_d,
  output logic [XLEN_P-1:0] pc_d,
  output logic [XLEN_P-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic [31:0]       fetch_count
);

  logic [XLEN_P-1:0] pc_plus4_f;
  logic [XLEN_P-1:0] pc_next;
  logic              pc_en;
  logic              ifid_load;

  logic [31:0]       instr_reg;
  logic [XLEN_P-1:0] pc_d_reg;
  logic [XLEN_P-1:0] pc_plus4_reg;
  logic              valid_reg;
  logic [31:0]       count_reg;

  // Wraps naturally at 2^XLEN; no trap on overflow.
  assign pc_plus4_f = pc_f + XLEN_P'(4);

  // Redirect wins over stall_f; target low bits are forced to word alignment.
  assign pc_next = pc_src_e ? {pc_target_e[XLEN_P-1:2], 2'b00} : pc_plus4_f;
  assign pc_en   = pc_src_e | ~stall_f;

  assign ifid_load = ~flush_d & ~stall_d;

  program_counter #(
    .W      (XLEN_P),
    .RST_PC (RESET_PC_P)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_en),
    .pc_next (pc_next),
    .pc      (pc_f)
  );

  assign imem_addr = pc_f;

  // IF/ID register: flush inserts a bubble, stall holds, otherwise capture the fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_reg    <= NOP_P;
      pc_d_reg     <= '0;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (flush_d) begin
      instr_reg    <= NOP_P;
      pc_d_reg     <= '0;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (!stall_d) begin
      instr_reg    <= imem_rd;
      pc_d_reg     <= pc_f;
      pc_plus4_reg <= pc_plus4_f;
      valid_reg    <= 1'b1;
    end
  end

  // Count every edge on which IF/ID accepts a new instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           count_reg <= '0;
    else if (ifid_load) count_reg <= count_reg + 32'd1;
  end

  assign instr_d     = instr_reg;
  assign pc_d        = pc_d_reg;
  assign pc_plus4_d  = pc_plus4_reg;
  assign valid_d     = valid_reg;
  assign fetch_count = count_reg;

endmodule
